// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM states and frame-format defaults for the tx and rx sides
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_PARITY_BIT = 0;
  localparam int UART_PARITY_ODD = 0;
  localparam int UART_STOP_BITS = 1;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with registered occupancy count and show-ahead read
module uart_sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [Width-1:0]        wdata,
  output logic [Width-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(Depth):0]  count
);
  localparam int AW = $clog2(Depth);
  logic [Width-1:0] mem [Depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(Depth);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter serialising start, LSB-first data, parity and stop bits
module uart_tx
  import uart_pkg::*;
#(
  parameter int BaudRate        = 9600,
  parameter int ClockFreqHz     = 10000000,
  parameter int ParityBit       = UART_PARITY_BIT,
  parameter int ParityOdd       = UART_PARITY_ODD,
  parameter int DataBitsSizeInt = UART_DATA_BITS,
  parameter int StopBitsSize    = UART_STOP_BITS,
  parameter int FifoDepth       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx_sig,
  output logic                        busy,
  output logic [$clog2(FifoDepth):0]  fifo_count
);
  localparam int SClkPeriod = ClockFreqHz / BaudRate;
  localparam int CntMax = StopBitsSize * SClkPeriod;
  localparam int CW = $clog2(CntMax) + 1;
  localparam int BW = $clog2(DataBitsSizeInt) + 1;
  localparam logic [7:0] DataMask = 8'((1 << DataBitsSizeInt) - 1);
  tx_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [7:0] sr, sr_n, head;
  logic par, par_n, load, full, empty, tx_n, bit_last, stop_last;
  uart_sync_fifo #(.Width(8), .Depth(FifoDepth)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_valid && tx_ready), .pop(load),
    .wdata(tx_data), .rdata(head), .full(full), .empty(empty), .count(fifo_count)
  );
  assign tx_ready = !full;
  assign busy = state != IDLE || !empty;
  assign bit_last = cnt == CW'(SClkPeriod - 1);
  assign stop_last = cnt == CW'(CntMax - 1);
  always_comb begin
    state_n = state;
    cnt_n = cnt + CW'(1);
    bit_n = bit_cnt;
    sr_n = sr;
    par_n = par;
    load = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        load = !empty;
      end
      START: if (bit_last) begin
        cnt_n = '0;
        state_n = DATA;
      end
      DATA: if (bit_last) begin
        cnt_n = '0;
        sr_n = sr >> 1;
        bit_n = bit_cnt + BW'(1);
        if (bit_cnt == BW'(DataBitsSizeInt - 1)) state_n = ParityBit != 0 ? PARITY : STOP;
      end
      PARITY: if (bit_last) begin
        cnt_n = '0;
        state_n = STOP;
      end
      STOP: if (stop_last) begin
        cnt_n = '0;
        state_n = IDLE;
        load = !empty;
      end
      default: begin
        cnt_n = '0;
        state_n = IDLE;
      end
    endcase
    // a pop from IDLE or from the end of STOP both start the next frame immediately
    if (load) begin
      state_n = START;
      sr_n = head;
      par_n = ^(head & DataMask) ^ (ParityOdd != 0);
      bit_n = '0;
    end
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? sr_n[0] : state_n == PARITY ? par_n : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_cnt <= '0;
      sr <= '0;
      par <= 1'b0;
      tx_sig <= 1'b1;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_cnt <= bit_n;
      sr <= sr_n;
      par <= par_n;
      tx_sig <= tx_n;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: checks several uart_tx formats against a frame-level reference model and line decoder
module tb_uart_tx;
  localparam int S = 10;
  typedef bit bitq_t[$];
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] data [5];
  logic [4:0] valid = '0;
  logic [4:0] ready, tx, busy;
  logic [4:0] cnt16 [4];
  logic [2:0] cnt4;
  bit trace [5][$];
  logic [7:0] exp_q [5][$];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx #(
      .BaudRate(1000000), .ClockFreqHz(10000000),
      .ParityBit((g == 1 || g == 2) ? 1 : 0), .ParityOdd(g == 2 ? 1 : 0),
      .DataBitsSizeInt(g == 3 ? 7 : 8), .StopBitsSize(g == 3 ? 2 : 1), .FifoDepth(16)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .tx_data(data[g]), .tx_valid(valid[g]), .tx_ready(ready[g]),
      .tx_sig(tx[g]), .busy(busy[g]), .fifo_count(cnt16[g])
    );
  end
  uart_tx #(
    .BaudRate(1000000), .ClockFreqHz(10000000), .ParityBit(0), .ParityOdd(0),
    .DataBitsSizeInt(8), .StopBitsSize(1), .FifoDepth(4)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[4]), .tx_valid(valid[4]), .tx_ready(ready[4]),
    .tx_sig(tx[4]), .busy(busy[4]), .fifo_count(cnt4)
  );
  always @(negedge clk)
    for (int k = 0; k < 5; k++) trace[k].push_back(tx[k]);
  function automatic int db(input int k); return k == 3 ? 7 : 8; endfunction
  function automatic int pb(input int k); return (k == 1 || k == 2) ? 1 : 0; endfunction
  function automatic int po(input int k); return k == 2 ? 1 : 0; endfunction
  function automatic int sb(input int k); return k == 3 ? 2 : 1; endfunction
  function automatic logic [7:0] mask(input int k); return 8'((1 << db(k)) - 1); endfunction
  function automatic bitq_t frame_bits(input int k, input logic [7:0] b);
    bitq_t q;
    int ones = 0;
    q.push_back(1'b0);
    for (int j = 0; j < db(k); j++) begin
      q.push_back(b[j]);
      ones += int'(b[j]);
    end
    if (pb(k) == 1) q.push_back(bit'((ones + po(k)) % 2));
    for (int j = 0; j < sb(k); j++) q.push_back(1'b1);
    return q;
  endfunction
  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
    end
  endtask
  task automatic push(input int k, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!ready[k] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!ready[k]) chk("ready_timeout", 0, 1);
    data[k] = b;
    valid[k] = 1'b1;
    exp_q[k].push_back(b & mask(k));
    @(posedge clk);
    #1 valid[k] = 1'b0;
  endtask
  task automatic wait_idle(input int k);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy[k] && n < 3000);
    chk("idle_timeout", busy[k], 0);
  endtask
  task automatic clear(input int k);
    @(posedge clk);
    trace[k].delete();
    exp_q[k].delete();
  endtask
  task automatic frame_check(input int k, input logic [7:0] b);
    bitq_t f = frame_bits(k, b & mask(k));
    @(negedge clk);
    chk("pre_start_tx", tx[k], 1);
    chk("busy_on", busy[k], 1);
    if (k < 4) chk("count_one", cnt16[k], 1);
    @(negedge clk);
    chk("start_edge", tx[k], 0);
    for (int j = 0; j < f.size(); j++) begin
      repeat (j == 0 ? 4 : S) @(negedge clk);
      chk($sformatf("bit%0d_k%0d", j, k), tx[k], f[j]);
    end
    repeat (S - 5) @(negedge clk);
    chk("last_cycle_busy", busy[k], 1);
    chk("last_cycle_tx", tx[k], 1);
    @(negedge clk);
    chk("frame_end_busy", busy[k], 0);
    exp_q[k].delete();
  endtask
  task automatic decode(input int k, input bit gaps);
    bitq_t q = trace[k];
    bitq_t f;
    int i = 1;
    int prev = -1;
    int len = (1 + db(k) + pb(k) + sb(k)) * S;
    logic [7:0] b;
    while (i + len <= q.size()) begin
      if (q[i-1] && !q[i]) begin
        b = '0;
        for (int j = 0; j < db(k); j++) b[j] = q[i + (1 + j) * S + S / 2];
        f = frame_bits(k, b);
        for (int j = 1 + db(k); j < f.size(); j++) chk("rx_tail", q[i + j * S + S / 2], f[j]);
        if (exp_q[k].size() == 0) chk("rx_extra", b, -1);
        else chk("rx_byte", b, exp_q[k].pop_front());
        if (gaps && prev >= 0) chk("rx_gap", i - prev, 0);
        prev = i + len;
        i += len;
      end else i++;
    end
    chk("rx_missing", exp_q[k].size(), 0);
    exp_q[k].delete();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int mc;
    bit acc;
    for (int k = 0; k < 5; k++) data[k] = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 5'h1f);
    chk("rst_ready", ready, 5'h1f);
    chk("rst_busy", busy, 0);
    chk("rst_count", cnt16[0], 0);
    chk("rst_count4", cnt4, 0);
    rst_n = 1'b1;
    push(0, 8'h55);
    frame_check(0, 8'h55);
    push(1, 8'h07);
    frame_check(1, 8'h07);
    push(2, 8'h07);
    frame_check(2, 8'h07);
    push(3, 8'h80);
    frame_check(3, 8'h80);
    clear(0);
    push(0, 8'hA5);
    push(0, 8'h3C);
    push(0, 8'hFF);
    wait_idle(0);
    decode(0, 1'b1);
    clear(4);
    mc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      data[4] = 8'(8'h10 + i);
      valid[4] = 1'b1;
      acc = mc < 4;
      if (acc) exp_q[4].push_back(data[4]);
      @(posedge clk);
      #1;
      mc += int'(acc);
      if (i == 1) mc--;
      chk($sformatf("full_ready%0d", i), ready[4], int'(mc < 4));
    end
    valid[4] = 1'b0;
    chk("full_count", cnt4, mc);
    wait_idle(4);
    decode(4, 1'b1);
    for (int k = 0; k < 5; k++) begin
      clear(k);
      repeat (6) begin
        repeat ($urandom_range(0, 25)) @(negedge clk);
        push(k, 8'($urandom));
      end
      wait_idle(k);
      decode(k, 1'b0);
    end
    clear(0);
    push(0, 8'h00);
    push(0, 8'hAA);
    push(0, 8'h33);
    repeat (34) @(negedge clk);
    chk("pre_rst_tx", tx[0], 0);
    chk("pre_rst_count", cnt16[0], 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", tx[0], 1);
    chk("rst_mid_count", cnt16[0], 0);
    chk("rst_mid_ready", ready[0], 1);
    chk("rst_mid_busy", busy[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear(0);
    repeat (300) @(negedge clk);
    chk("post_rst_busy", busy[0], 0);
    decode(0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
